vector_alu_exec: RTL and testbench

//  Execution end of the control unit's ALU decode path: consumes {ALUControl, SrcA}
//  and executes the op lane-by-lane over a packed vector operand pair.

---
 rtl/vector_alu_exec.sv | 199 +++++++++++++++++++
 tb/tb_vector_alu_exec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_exec.sv
// rtl/vector_alu_exec.sv - lane-serial vector ALU with iterative restoring divider
module vector_alu_exec #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             ALUControl,
   input  logic                   SrcA,
   input  logic [LANES*WIDTH-1:0] op_a,
   input  logic [LANES*WIDTH-1:0] op_b,
   output logic                   busy,
   output logic                   done,
   output logic [LANES*WIDTH-1:0] result,
   output logic [LANES-1:0]       cmp_mask,
   output logic [LANES-1:0]       div0_mask,
   output logic                   zero
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MOV = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC    = 2'd1,
      S_DIVITER = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             op_q, op_d;
   logic                   srca_q, srca_d;
   logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [LW-1:0]          lane_q, lane_d;
   logic [IW-1:0]          iter_q, iter_d;
   logic [WIDTH-1:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [LANES*WIDTH-1:0] result_q, result_d;
   logic [LANES-1:0]       cmp_q, cmp_d, div0_q, div0_d;
   logic                   zero_q, zero_d;

   logic [WIDTH-1:0]       a_lane, b_lane, mul_lane;
   logic [WIDTH:0]         rem_shift, trial;
   logic                   last_lane, last_iter, is_nop;

   assign a_lane    = srca_q ? '0 : a_q[lane_q*WIDTH +: WIDTH];
   assign b_lane    = b_q[lane_q*WIDTH +: WIDTH];
   assign mul_lane  = a_lane * b_lane;
   assign last_lane = (lane_q == LW'(LANES - 1));
   assign last_iter = (iter_q == IW'(WIDTH - 1));
   assign is_nop    = (ALUControl[2:1] == 2'b11);

   // One restoring-division step: shift in the next dividend bit, subtract if it fits
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, dvs_q};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: one EXEC cycle per lane, DIV adds WIDTH DIVITER cycles per lane
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = is_nop ? S_DONE : S_EXEC;
         S_EXEC: begin
            if (op_q == OP_DIV) state_d = S_DIVITER;
            else if (last_lane) state_d = S_DONE;
         end
         S_DIVITER: if (last_iter) state_d = last_lane ? S_DONE : S_EXEC;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // Datapath next-state: operand capture, per-lane execute, divider iteration
   always_comb begin
      op_d     = op_q;
      srca_d   = srca_q;
      a_d      = a_q;
      b_d      = b_q;
      lane_d   = lane_q;
      iter_d   = iter_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      cmp_d    = cmp_q;
      div0_d   = div0_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = ALUControl;
               srca_d = SrcA;
               a_d    = op_a;
               b_d    = op_b;
               lane_d = '0;
               cmp_d  = '0;
               div0_d = '0;
            end
         end
         S_EXEC: begin
            lane_d = lane_q + LW'(1);
            case (op_q)
               OP_ADD: result_d[lane_q*WIDTH +: WIDTH] = a_lane + b_lane;
               OP_SUB: result_d[lane_q*WIDTH +: WIDTH] = a_lane - b_lane;
               OP_MOV: result_d[lane_q*WIDTH +: WIDTH] = b_lane;
               OP_MUL: result_d[lane_q*WIDTH +: WIDTH] = mul_lane;
               OP_CMP: begin
                  result_d[lane_q*WIDTH +: WIDTH] = a_lane - b_lane;
                  cmp_d[lane_q] = (a_lane == b_lane);
               end
               OP_DIV: begin
                  lane_d         = lane_q;
                  rem_d          = '0;
                  quo_d          = a_lane;
                  dvs_d          = b_lane;
                  iter_d         = '0;
                  div0_d[lane_q] = (b_lane == '0);
               end
               default: lane_d = lane_q;
            endcase
         end
         S_DIVITER: begin
            iter_d = iter_q + IW'(1);
            // A zero divisor always "fits", which yields the all-ones quotient naturally
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (last_iter) begin
               result_d[lane_q*WIDTH +: WIDTH] = quo_d;
               lane_d = lane_q + LW'(1);
            end
         end
         default: ;
      endcase
      // Zero flag is refreshed on entry to DONE so it is valid alongside done
      if (state_d == S_DONE && state_q != S_DONE) zero_d = (result_d == '0);
   end

   // Datapath registers; reset discards any partially written result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         srca_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         lane_q   <= '0;
         iter_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         cmp_q    <= '0;
         div0_q   <= '0;
         zero_q   <= 1'b0;
      end else begin
         op_q     <= op_d;
         srca_q   <= srca_d;
         a_q      <= a_d;
         b_q      <= b_d;
         lane_q   <= lane_d;
         iter_q   <= iter_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         cmp_q    <= cmp_d;
         div0_q   <= div0_d;
         zero_q   <= zero_d;
      end
   end

   assign result    = result_q;
   assign cmp_mask  = cmp_q;
   assign div0_mask = div0_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_vector_alu_exec.sv
// tb/tb_vector_alu_exec.sv - scoreboard bench for vector_alu_exec with reference model
module tb_vector_alu_exec;

   localparam int W = 16;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [2:0]     ALUControl = 3'b000;
   logic           SrcA = 1'b0;
   logic [L*W-1:0] op_a = '0;
   logic [L*W-1:0] op_b = '0;
   logic           busy, done, zero;
   logic [L*W-1:0] result;
   logic [L-1:0]   cmp_mask, div0_mask;

   vector_alu_exec #(.WIDTH(W), .LANES(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl), .SrcA(SrcA),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
      .cmp_mask(cmp_mask), .div0_mask(div0_mask), .zero(zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [L*W-1:0] res;
      logic [L-1:0]   cmp;
      logic [L-1:0]   div0;
      logic           zero;
      int             cyc;
   } exp_t;

   exp_t           sbq[$];
   logic [L*W-1:0] model_res = '0;
   int             total = 0;
   int             bad = 0;
   int             n_done = 0;
   int             n_exp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [L*W-1:0] pk(input logic [15:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   // Reference model: computes the whole vector response from the operation's definition
   task automatic model(input logic [2:0] op, input logic srca, input logic [L*W-1:0] a,
                        input logic [L*W-1:0] b, output exp_t e);
      logic [W-1:0] av, bv, r;
      int lat;
      e.res  = model_res;
      e.cmp  = '0;
      e.div0 = '0;
      for (int i = 0; i < L; i++) begin
         av = srca ? '0 : a[i*W +: W];
         bv = b[i*W +: W];
         r  = model_res[i*W +: W];
         case (op)
            3'b000: r = av + bv;
            3'b001: r = av - bv;
            3'b010: r = bv;
            3'b011: r = av * bv;
            3'b100: begin
               if (bv == 0) begin r = '1; e.div0[i] = 1'b1; end
               else r = av / bv;
            end
            3'b101: begin r = av - bv; e.cmp[i] = (av == bv); end
            default: ;
         endcase
         e.res[i*W +: W] = r;
      end
      if (op[2:1] == 2'b11) lat = 1;
      else if (op == 3'b100) lat = L * (W + 1) + 1;
      else lat = L + 1;
      model_res = e.res;
      e.zero = (e.res == '0);
      e.cyc  = cyc + lat;
   endtask

   // Drive one request; operands and controls are scrambled right after acceptance
   task automatic issue(input logic [2:0] op, input logic srca, input logic [L*W-1:0] a,
                        input logic [L*W-1:0] b);
      exp_t e;
      @(negedge clk);
      ALUControl = op; SrcA = srca; op_a = a; op_b = b; start = 1'b1;
      model(op, srca, a, b, e);
      sbq.push_back(e);
      n_exp++;
      @(negedge clk);
      start = 1'b0;
      ALUControl = 3'($urandom);
      SrcA = 1'($urandom);
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic run(input logic [2:0] op, input logic srca, input logic [L*W-1:0] a,
                      input logic [L*W-1:0] b);
      issue(op, srca, a, b);
      wait_idle();
   endtask

   // Monitor: every done pulse retires the oldest expected response
   always @(negedge clk) begin
      if (rst_n && done) begin
         n_done++;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("result", result, e.res);
            chk("cmp_mask", 64'(cmp_mask), 64'(e.cmp));
            chk("div0_mask", 64'(div0_mask), 64'(e.div0));
            chk("zero", 64'(zero), 64'(e.zero));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy_at_done", 64'(busy), 64'd1);
         end
      end
   end

   function automatic logic [L*W-1:0] rand_vec(input int zmask);
      logic [L*W-1:0] v;
      for (int i = 0; i < L; i++) begin
         case ($urandom_range(0, 3))
            0:       v[i*W +: W] = (zmask != 0) ? '0 : W'($urandom_range(0, 3));
            1:       v[i*W +: W] = W'($urandom_range(0, 15));
            default: v[i*W +: W] = W'($urandom);
         endcase
      end
      return v;
   endfunction

   initial begin
      logic [L*W-1:0] ra, rb;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_masks", 64'({cmp_mask, div0_mask}), 64'd0);
      chk("rst_zero", 64'(zero), 64'd0);
      rst_n = 1'b1;

      // Directed vectors
      run(3'b000, 1'b0, pk(1, 2, 3, 16'hFFFF), pk(1, 1, 1, 1));
      run(3'b101, 1'b0, pk(5, 7, 0, 9), pk(5, 8, 0, 1));
      run(3'b000, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      run(3'b011, 1'b0, pk(300, 16'h0100, 0, 1), pk(200, 16'h0100, 5, 1));
      run(3'b001, 1'b1, pk(9, 9, 9, 9), pk(1, 0, 0, 0));
      run(3'b100, 1'b0, pk(100, 5, 16'hFFFF, 0), pk(7, 0, 1, 3));
      run(3'b010, 1'b1, pk(1, 1, 1, 1), pk(9, 8, 7, 6));
      run(3'b111, 1'b0, pk(0, 0, 0, 0), pk(0, 0, 0, 0));
      run(3'b001, 1'b0, pk(4, 5, 6, 7), pk(4, 5, 6, 7));
      run(3'b110, 1'b1, pk(1, 2, 3, 4), pk(1, 2, 3, 4));

      // Randomized operations, some back-to-back
      for (int n = 0; n < 40; n++) begin
         ra = rand_vec(0);
         rb = rand_vec(1);
         if ($urandom_range(0, 3) == 0) rb = ra;
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0), ra, rb);
         wait_idle();
      end

      // Start pulsed while a DIV is in flight must be ignored
      issue(3'b100, 1'b0, pk(1000, 77, 3, 0), pk(10, 7, 0, 2));
      repeat (8) @(negedge clk);
      ALUControl = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      // Reset in the middle of a DIV aborts it with nothing written back
      issue(3'b100, 1'b0, pk(50, 60, 70, 80), pk(3, 4, 5, 6));
      repeat (28) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_result", result, 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      sbq.delete();
      n_exp--;
      model_res = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(3'b000, 1'b0, pk(10, 20, 30, 40), pk(1, 2, 3, 4));

      repeat (4) @(negedge clk);
      chk("done_count", 64'(n_done), 64'(n_exp));
      chk("queue_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
